instruction_ram_loader: RTL and testbench
=========================================

// Module: instruction_ram_loader
// PURPOSE
//  Parametrised instruction memory for the processor fetch stage, with a built-in program loader.
//  After reset it sweeps all words to FILL_WORD. A host then streams a program in through a valid/ready loader port.
//  The fetch port has a registered, 1-cycle read. Fetch is blocked while the memory is being cleared or loaded.
// PARAMETERS
//  DATA_WIDTH  32            instruction word width
//  ADDR_WIDTH  10            address width, fetch and load
//  DEPTH       1024          number of words; legal range 2..2**ADDR_WIDTH
//  FILL_WORD   32'h6C000000  value written by the clear sweep and returned on a fault (Nop encoding)
// PORTS
//  clock         in   1             rising-edge clock
//  reset         in   1             synchronous, active-high
//  fetch_en      in   1             fetch request; sampled only when fetch_ready=1
//  fetch_addr    in   ADDR_WIDTH    word address to fetch
//  fetch_ready   out  1             1 only in RUN state
//  fetch_valid   out  1             fetch_data valid; one cycle after an accepted fetch
//  fetch_data    out  DATA_WIDTH    registered read data
//  fetch_fault   out  1             pulses with fetch_valid when fetch_addr >= DEPTH
//  load_start    in   1             begin a load; accepted only in RUN
//  load_base     in   ADDR_WIDTH    first write address, sampled with load_start
//  load_count    in   ADDR_WIDTH+1  number of words, sampled with load_start
//  load_valid    in   1             load_data present
//  load_data     in   DATA_WIDTH    program word
//  load_ready    out  1             1 in LOAD state; a word transfers when load_valid & load_ready
//  load_done     out  1             1-cycle pulse when the last word has been written
//  busy          out  1             1 in CLEAR or LOAD state
// BEHAVIOUR
//  Reset: state=CLEAR, clear pointer=0.
//   All outputs read 0 except busy=1; fetch_data=0.
//   Reset asserted mid-load abandons the load and restarts the clear sweep.
//  CLEAR: writes FILL_WORD to address ptr each cycle, ptr increments.
//   When ptr=DEPTH-1 has been written, the next state is RUN. The sweep takes exactly DEPTH cycles.
//  RUN: fetch_ready=1. When fetch_en=1:
//   - next cycle, fetch_valid=1 and fetch_data=mem[fetch_addr];
//   - if the address is >= DEPTH: fetch_data=FILL_WORD and fetch_fault=1.
//   fetch_data holds its last value when no fetch is accepted.
//  RUN, load_start=1: base and count are latched and the state goes to LOAD the next cycle.
//   If fetch_en is also 1 that cycle, the fetch is still served.
//   If count=0: no LOAD cycles; load_done pulses next cycle and the state stays RUN.
//  LOAD: load_ready=1. Each handshake writes load_data at the write pointer, then:
//   - the pointer increments, wrapping DEPTH-1 -> 0 (base >= DEPTH is reduced modulo DEPTH at latch);
//   - the remaining count decrements.
//   On the handshake that takes remaining to 0: load_done pulses next cycle, state returns to RUN, load_ready drops.
//   load_start in LOAD is ignored. load_valid stalls are allowed indefinitely.
//  Write/read ordering: a fetch issued the cycle after a write to the same address returns the new word.
// CONFIGURATION
//  IRAM_PARITY_EN defined:
//   - each word stores an extra even-parity bit, computed on every write, including clear words;
//   - output parity_error (1 bit) pulses with fetch_valid when the stored parity mismatches;
//   - fault fetches never flag parity_error.
//  Not defined: no parity storage, and no parity_error port.
// STRUCTURE
//  Shared package iram_pkg:
//   - state enum {CLEAR, RUN, LOAD};
//   - FILL_WORD default (NOP_WORD) and HALT_WORD opcode constants.
//  One sub-module: iram_sp_array, a single-port synchronous array holding DEPTH x (DATA_WIDTH[+1]) words.
//   It has a write port and a registered read port. The top holds the FSM, pointers and handshake logic.
// TESTING
//  1 Reset, DEPTH=16 -> busy=1 for 16 cycles then fetch_ready=1; fetch each addr 0..15 returns 32'h6C000000.
//  2 load_start base=3 count=4; words A1..A4 with a stall after A2
//     -> mem[3..6]=A1..A4, load_done pulses exactly once, then RUN.
//  3 Wrap: DEPTH=16, base=14 count=3 -> words written to 14, 15, 0; fetch 0 returns the third word.
//  4 fetch_addr=20 with DEPTH=16, ADDR_WIDTH=5 -> fetch_valid=1, fetch_fault=1, data=FILL_WORD.
//  5 reset asserted after 2 of 5 words -> CLEAR restarts, the 2 written words read back as FILL_WORD afterwards.
//  6 load_count=0 -> load_done the next cycle and busy stays 0; with IRAM_PARITY_EN, a forced bit flip in the array
//     -> parity_error=1 on fetch.

Source files
------------

// File: rtl/iram_pkg.sv
// Shared types and opcode constants for the instruction RAM loader.
// Exports the loader state enum, NOP/HALT words and a parity helper.
package iram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } iram_state_e;

  localparam logic [31:0] NOP_WORD  = 32'h6C00_0000;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_par32(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/iram_sp_array.sv
// Single-port synchronous word array: one write port, registered read.
// Ports: i_clk, i_reset (clears read register only), i_we/i_waddr/i_wdata,
//        i_re/i_raddr, o_rdata (holds when i_re=0).
module iram_sp_array #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_ram_loader.sv
// Instruction memory with clear sweep, streaming loader and 1-cycle fetch.
// Ports: i_clock/i_reset, fetch port (i_fetch_*, o_fetch_*), loader port
//        (i_load_*, o_load_ready, o_load_done), o_busy. Optional parity
//        storage and o_parity_error when IRAM_PARITY_EN is defined.
module instruction_ram_loader
  import iram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = NOP_WORD
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_fetch_en,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  output logic                  o_fetch_ready,
  output logic                  o_fetch_valid,
  output logic [DATA_WIDTH-1:0] o_fetch_data,
  output logic                  o_fetch_fault,
  input  logic                  i_load_start,
  input  logic [ADDR_WIDTH-1:0] i_load_base,
  input  logic [ADDR_WIDTH:0]   i_load_count,
  input  logic                  i_load_valid,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic                  o_load_ready,
  output logic                  o_load_done,
  output logic                  o_busy
`ifdef IRAM_PARITY_EN
  ,
  output logic                  o_parity_error
`endif
);

`ifdef IRAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int WW = DATA_WIDTH + PW;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  iram_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_remain;
  logic                  r_valid;
  logic                  r_fault;
  logic                  r_done;

  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [WW-1:0]         w_wdata;
  logic                  w_re;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [WW-1:0]         w_rdata;
  logic [DATA_WIDTH-1:0] w_wword;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic [ADDR_WIDTH-1:0] w_base_mod;

  assign w_in_range = {1'b0, i_fetch_addr} < DEPTH_W;
  assign w_ptr_nxt  = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
  // Out-of-range bases fold back into the array once, at latch time.
  assign w_base_mod = ADDR_WIDTH'({1'b0, i_load_base} % DEPTH_W);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr;
    w_wword = FILL_WORD;
    w_re    = 1'b0;
    w_raddr = i_fetch_addr;
    unique case (1'b1)
      (r_state == ST_CLEAR): begin
        w_we = 1'b1;
      end
      (r_state == ST_LOAD): begin
        w_we    = i_load_valid;
        w_wword = i_load_data;
      end
      (r_state == ST_RUN): begin
        w_re = i_fetch_en & w_in_range;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

`ifdef IRAM_PARITY_EN
  assign w_wdata = {^w_wword, w_wword};
`else
  assign w_wdata = w_wword;
`endif

  iram_sp_array #(
    .WIDTH      (WW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .i_clk   (i_clock),
    .i_reset (i_reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_CLEAR;
      r_ptr    <= '0;
      r_remain <= '0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        ST_CLEAR: begin
          r_ptr <= w_ptr_nxt;
          if (r_ptr == LAST) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_fetch_en) begin
            r_valid <= 1'b1;
            r_fault <= ~w_in_range;
          end
          if (i_load_start) begin
            if (i_load_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_ptr    <= w_base_mod;
              r_remain <= i_load_count;
              r_state  <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (i_load_valid) begin
            r_ptr    <= w_ptr_nxt;
            r_remain <= r_remain - 1'b1;
            if (r_remain == (ADDR_WIDTH+1)'(1)) begin
              r_done  <= 1'b1;
              r_state <= ST_RUN;
            end
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  assign o_fetch_ready = (r_state == ST_RUN);
  assign o_load_ready  = (r_state == ST_LOAD);
  assign o_busy        = (r_state == ST_CLEAR) | (r_state == ST_LOAD);
  assign o_load_done   = r_done;
  assign o_fetch_valid = r_valid;
  assign o_fetch_fault = r_valid & r_fault;
  // r_fault persists between fetches so a faulted read keeps showing FILL.
  assign o_fetch_data  = r_fault ? FILL_WORD : w_rdata[DATA_WIDTH-1:0];

`ifdef IRAM_PARITY_EN
  assign o_parity_error = r_valid & ~r_fault & (^w_rdata);
`endif

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Randomised bench for instruction_ram_loader (DEPTH=16, ADDR_WIDTH=5).
// Reference: a plain word array updated from the load/clear rules.
module tb_instruction_ram_loader;
  import iram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DP = 16;
  localparam logic [31:0] FILL = NOP_WORD;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          fetch_fault;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_count;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic          busy;
`ifdef IRAM_PARITY_EN
  logic          parity_error;
`endif

  always #5 clk = ~clk;

  instruction_ram_loader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DP),
    .FILL_WORD  (FILL)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_fetch_en    (fetch_en),
    .i_fetch_addr  (fetch_addr),
    .o_fetch_ready (fetch_ready),
    .o_fetch_valid (fetch_valid),
    .o_fetch_data  (fetch_data),
    .o_fetch_fault (fetch_fault),
    .i_load_start  (load_start),
    .i_load_base   (load_base),
    .i_load_count  (load_count),
    .i_load_valid  (load_valid),
    .i_load_data   (load_data),
    .o_load_ready  (load_ready),
    .o_load_done   (load_done),
    .o_busy        (busy)
`ifdef IRAM_PARITY_EN
    ,
    .o_parity_error (parity_error)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model [DP];
  logic [31:0] last_exp;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < DP; i++) model[i] = FILL;
  endtask

  task automatic wait_ready(input string tag);
    int c = 0;
    while (!fetch_ready && c < 100) begin
      chk({tag, "_busy"}, busy, 1);
      tick;
      c++;
    end
    chk({tag, "_clear_cycles"}, c, DP);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  function automatic logic [31:0] expect_word(input logic [AW-1:0] a);
    return (int'(a) >= DP) ? FILL : model[int'(a) % DP];
  endfunction

  task automatic do_fetch(input logic [AW-1:0] a);
    logic [31:0] e;
    e = expect_word(a);
    fetch_en   = 1'b1;
    fetch_addr = a;
    tick;
    fetch_en = 1'b0;
    chk("fetch_valid", fetch_valid, 1);
    chk("fetch_fault", fetch_fault, int'(a) >= DP);
    chk($sformatf("fetch_data[%0d]", a), fetch_data, e);
`ifdef IRAM_PARITY_EN
    chk("parity_ok", parity_error, 0);
`endif
    last_exp = e;
  endtask

  task automatic do_load(input logic [AW-1:0] base, input int cnt,
                         input int max_stall, input int stall_after,
                         input bit with_fetch);
    int          dones = 0;
    int          wp;
    int          st;
    logic [31:0] d;
    logic [31:0] fe;
    logic [AW-1:0] fa;
    fa = AW'($urandom_range(31, 0));
    fe = expect_word(fa);
    load_start = 1'b1;
    load_base  = base;
    load_count = (AW+1)'(cnt);
    fetch_en   = with_fetch;
    fetch_addr = fa;
    tick;
    load_start = 1'b0;
    fetch_en   = 1'b0;
    if (with_fetch) begin
      chk("co_fetch_valid", fetch_valid, 1);
      chk("co_fetch_data", fetch_data, fe);
    end
    if (cnt == 0) begin
      chk("cnt0_done", load_done, 1);
      chk("cnt0_busy", busy, 0);
      tick;
      chk("cnt0_done_pulse", load_done, 0);
      chk("cnt0_ready", fetch_ready, 1);
      return;
    end
    chk("load_ready", load_ready, 1);
    chk("load_busy", busy, 1);
    wp = int'(base) % DP;
    for (int i = 0; i < cnt; i++) begin
      st = $urandom_range(max_stall, 0);
      if (i == stall_after) st += 3;
      repeat (st) begin
        load_valid = 1'b0;
        // load_start while loading must be ignored
        load_start = $urandom_range(1, 0);
        load_base  = AW'($urandom);
        tick;
        load_start = 1'b0;
        if (load_done) dones++;
      end
      d = $urandom;
      load_valid = 1'b1;
      load_data  = d;
      tick;
      if (load_done) dones++;
      model[wp] = d;
      wp = (wp + 1) % DP;
    end
    load_valid = 1'b0;
    tick;
    if (load_done) dones++;
    chk("load_done_once", dones, 1);
    chk("load_ready_drop", load_ready, 0);
    chk("run_after_load", fetch_ready, 1);
  endtask

  initial begin
    rst        = 1'b1;
    fetch_en   = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_base  = '0;
    load_count = '0;
    load_valid = 1'b0;
    load_data  = '0;
    last_exp   = '0;
    model_clear();
    tick;
    tick;
    chk("rst_busy", busy, 1);
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_fetch_fault", fetch_fault, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_load_done", load_done, 0);
    rst = 1'b0;
    wait_ready("boot");

    for (int a = 0; a < DP; a++) do_fetch(AW'(a));

    do_load(5'd3, 4, 0, 1, 1'b1);
    for (int a = 3; a <= 6; a++) do_fetch(AW'(a));

    // Idle cycle: data holds the last fetched word
    tick;
    chk("hold_valid", fetch_valid, 0);
    chk("hold_data", fetch_data, last_exp);

    do_load(5'd14, 3, 1, -1, 1'b0);
    do_fetch(5'd14);
    do_fetch(5'd15);
    do_fetch(5'd0);

    do_fetch(5'd20);
    tick;
    chk("fault_hold_data", fetch_data, FILL);
    chk("fault_pulse", fetch_fault, 0);

    do_load(5'd9, 0, 0, -1, 1'b0);

    // Base beyond DEPTH folds modulo DEPTH
    do_load(5'd27, 2, 1, -1, 1'b0);
    do_fetch(5'd11);
    do_fetch(5'd12);

    // Reset mid-load abandons it and re-clears everything
    load_start = 1'b1;
    load_base  = 5'd5;
    load_count = 6'd5;
    tick;
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom;
      tick;
    end
    load_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("midrst_busy", busy, 1);
    chk("midrst_load_ready", load_ready, 0);
    rst = 1'b0;
    model_clear();
    wait_ready("reboot");
    do_fetch(5'd5);
    do_fetch(5'd6);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(3, 0) != 0) begin
        do_fetch(AW'($urandom_range(31, 0)));
      end else begin
        do_load(AW'($urandom_range(31, 0)), $urandom_range(20, 0),
                2, -1, 1'($urandom_range(1, 0)));
      end
    end

`ifdef IRAM_PARITY_EN
    dut.u_array.r_mem[2][0] = ~dut.u_array.r_mem[2][0];
    fetch_en   = 1'b1;
    fetch_addr = 5'd2;
    tick;
    fetch_en = 1'b0;
    chk("parity_flip_valid", fetch_valid, 1);
    chk("parity_flip_err", parity_error, 1);
    chk("parity_flip_data", fetch_data, model[2] ^ 32'h1);
    do_fetch(5'd25);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
